alu_unit: RTL and testbench

//  Registered 8-bit ALU: AND, OR, ADD, SUB on two operands, selected by a 2-bit control.

---
 rtl/alu_unit.sv | 107 ++++++++++
 tb/tb_alu_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// Registered execute-stage ALU: AND/OR/ADD/SUB with Z/N/C/V condition flags.
// One-cycle latency; out_valid follows in_valid, result and flags hold on idle cycles.

package alu_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned MSB = WIDTH - 1;

  alu_op_e          op_c;
  logic [WIDTH-1:0] b_op_c;
  logic             cin_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] result_c;
  alu_flags_t       flags_c;

  assign op_c = alu_op_e'(alu_control);

  // Shared adder: SUB reuses it as a + ~b + 1 so carry means "no borrow".
  always_comb begin
    b_op_c = b;
    cin_c  = 1'b0;
    if (op_c == OP_SUB) begin
      b_op_c = ~b;
      cin_c  = 1'b1;
    end
    sum_c = (WIDTH+1)'(a) + (WIDTH+1)'(b_op_c) + (WIDTH+1)'(cin_c);
  end

  // Result select and flag generation; every encoding is decoded explicitly.
  always_comb begin
    result_c         = '0;
    flags_c          = '0;
    case (op_c)
      OP_AND: result_c = a & b;
      OP_OR:  result_c = a | b;
      OP_ADD: begin
        result_c         = sum_c[WIDTH-1:0];
        flags_c.carry    = sum_c[WIDTH];
        flags_c.overflow = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result_c         = sum_c[WIDTH-1:0];
        flags_c.carry    = sum_c[WIDTH];
        flags_c.overflow = (a[MSB] != b[MSB]) && (sum_c[MSB] != a[MSB]);
      end
      default: result_c = '0;
    endcase
    flags_c.zero     = (result_c == '0);
    flags_c.negative = result_c[MSB];
  end

  // Output register; reset wins over a simultaneous valid operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result <= '0;
      out_valid  <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result <= result_c;
        zero       <= flags_c.zero;
        negative   <= flags_c.negative;
        carry      <= flags_c.carry;
        overflow   <= flags_c.overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: hand-computed vectors per operation, hold and reset behaviour.
// Observed word layout: {out_valid, alu_result[7:0], zero, negative, carry, overflow}.

module tb_alu_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] alu_control;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       zero;
  logic       negative;
  logic       carry;
  logic       overflow;

  int n_vec;
  int n_err;

  localparam logic [1:0] C_AND = 2'b00;
  localparam logic [1:0] C_OR  = 2'b01;
  localparam logic [1:0] C_ADD = 2'b10;
  localparam logic [1:0] C_SUB = 2'b11;

  alu_unit #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] snap();
    return {out_valid, alu_result, zero, negative, carry, overflow};
  endfunction

  // Drive one valid operation at the falling edge and sample 1 ns after the next rising edge.
  task automatic issue(input logic [1:0] ctl, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = ctl;
    a           = x;
    b           = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid    = 1'b0;
    alu_control = C_ADD;
    a           = x;
    b           = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    alu_control = C_OR;
    a           = 8'hA5;
    b           = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    obs = snap();
    n_vec++;
    if (obs !== 13'b0_00000000_0000) begin
      n_err++;
      $display("FAIL reset_state: got %b exp %b", obs, 13'b0_00000000_0000);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_and();
    logic [12:0] obs;
    issue(C_AND, 8'h01, 8'h00);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1000}) begin
      n_err++;
      $display("FAIL and_zero: got %b exp %b", obs, {1'b1, 8'h00, 4'b1000});
    end
    issue(C_AND, 8'hFF, 8'h80);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h80, 4'b0100}) begin
      n_err++;
      $display("FAIL and_neg: got %b exp %b", obs, {1'b1, 8'h80, 4'b0100});
    end
  endtask

  task automatic test_or();
    logic [12:0] obs;
    issue(C_OR, 8'h01, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h01, 4'b0000}) begin
      n_err++;
      $display("FAIL or_one: got %b exp %b", obs, {1'b1, 8'h01, 4'b0000});
    end
    issue(C_OR, 8'h00, 8'h00);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1000}) begin
      n_err++;
      $display("FAIL or_zero: got %b exp %b", obs, {1'b1, 8'h00, 4'b1000});
    end
  endtask

  task automatic test_add();
    logic [12:0] obs;
    issue(C_ADD, 8'h01, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h02, 4'b0000}) begin
      n_err++;
      $display("FAIL add_simple: got %b exp %b", obs, {1'b1, 8'h02, 4'b0000});
    end
    issue(C_ADD, 8'hFF, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1010}) begin
      n_err++;
      $display("FAIL add_carry: got %b exp %b", obs, {1'b1, 8'h00, 4'b1010});
    end
    // Logic op right after a carry must clear carry/overflow.
    issue(C_AND, 8'h0F, 8'h03);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h03, 4'b0000}) begin
      n_err++;
      $display("FAIL and_clears_carry: got %b exp %b", obs, {1'b1, 8'h03, 4'b0000});
    end
    issue(C_ADD, 8'h7F, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h80, 4'b0101}) begin
      n_err++;
      $display("FAIL add_overflow: got %b exp %b", obs, {1'b1, 8'h80, 4'b0101});
    end
  endtask

  task automatic test_sub();
    logic [12:0] obs;
    issue(C_SUB, 8'h02, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h01, 4'b0010}) begin
      n_err++;
      $display("FAIL sub_simple: got %b exp %b", obs, {1'b1, 8'h01, 4'b0010});
    end
    issue(C_SUB, 8'h00, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'hFF, 4'b0100}) begin
      n_err++;
      $display("FAIL sub_borrow: got %b exp %b", obs, {1'b1, 8'hFF, 4'b0100});
    end
    issue(C_SUB, 8'h80, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h7F, 4'b0011}) begin
      n_err++;
      $display("FAIL sub_overflow: got %b exp %b", obs, {1'b1, 8'h7F, 4'b0011});
    end
    issue(C_SUB, 8'h55, 8'h55);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1010}) begin
      n_err++;
      $display("FAIL sub_equal: got %b exp %b", obs, {1'b1, 8'h00, 4'b1010});
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs;
    issue(C_ADD, 8'h10, 8'h20);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h30, 4'b0000}) begin
      n_err++;
      $display("FAIL b2b_add: got %b exp %b", obs, {1'b1, 8'h30, 4'b0000});
    end
    issue(C_SUB, 8'h30, 8'h10);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h20, 4'b0010}) begin
      n_err++;
      $display("FAIL b2b_sub: got %b exp %b", obs, {1'b1, 8'h20, 4'b0010});
    end
    issue(C_OR, 8'hF0, 8'h0F);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'hFF, 4'b0100}) begin
      n_err++;
      $display("FAIL b2b_or: got %b exp %b", obs, {1'b1, 8'hFF, 4'b0100});
    end
  endtask

  task automatic test_hold();
    logic [12:0] obs;
    idle(8'h00, 8'h00);
    obs = snap();
    n_vec++;
    if (obs !== {1'b0, 8'hFF, 4'b0100}) begin
      n_err++;
      $display("FAIL hold_first: got %b exp %b", obs, {1'b0, 8'hFF, 4'b0100});
    end
    idle(8'hFF, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b0, 8'hFF, 4'b0100}) begin
      n_err++;
      $display("FAIL hold_second: got %b exp %b", obs, {1'b0, 8'hFF, 4'b0100});
    end
  endtask

  task automatic test_reset_midstream();
    logic [12:0] obs;
    issue(C_ADD, 8'hFF, 8'h01);
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h00, 4'b1010}) begin
      n_err++;
      $display("FAIL pre_reset_op: got %b exp %b", obs, {1'b1, 8'h00, 4'b1010});
    end
    @(negedge clk);
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    alu_control = C_ADD;
    a           = 8'h05;
    b           = 8'h03;
    @(posedge clk);
    #1;
    obs = snap();
    n_vec++;
    if (obs !== 13'b0_00000000_0000) begin
      n_err++;
      $display("FAIL reset_wins: got %b exp %b", obs, 13'b0_00000000_0000);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    alu_control = C_SUB;
    @(posedge clk);
    #1;
    obs = snap();
    n_vec++;
    if (obs !== {1'b1, 8'h02, 4'b0010}) begin
      n_err++;
      $display("FAIL post_reset_op: got %b exp %b", obs, {1'b1, 8'h02, 4'b0010});
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_and();
    test_or();
    test_add();
    test_sub();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
